// File: rtl/demux_deserializer.sv
// rtl/demux_deserializer.sv - 1-to-N demultiplexing deserializer, LSB first
module demux_deserializer #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          din,
  input  logic          din_valid,
  input  logic          sync,
  output logic [SW-1:0] sel,
  output logic [N-1:0]  q,
  output logic          q_valid,
  output logic          busy,
  output logic          frame_err
);

  typedef enum logic {IDLE, COLLECT} state_t;

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  state_t       state;
  logic [N-1:0] shift;
  logic [N-1:0] word;

  // Partial word with the current bit dropped into its slot; becomes q on completion.
  always_comb begin
    word      = shift;
    word[sel] = din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift     <= '0;
      sel       <= '0;
      q         <= '0;
      q_valid   <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
      if (sync) begin
        // A sync restarts framing; a bit presented with it is bit 0 of the new frame.
        frame_err <= (state == COLLECT);
        if (din_valid) begin
          shift <= {{(N-1){1'b0}}, din};
          sel   <= SW'(1);
          state <= COLLECT;
          busy  <= 1'b1;
        end else begin
          shift <= '0;
          sel   <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else if (din_valid) begin
        if (sel == LAST) begin
          q       <= word;
          q_valid <= 1'b1;
          shift   <= '0;
          sel     <= '0;
          state   <= IDLE;
          busy    <= 1'b0;
        end else begin
          shift <= word;
          sel   <= sel + SW'(1);
          state <= COLLECT;
          busy  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_deserializer.sv
// tb/tb_demux_deserializer.sv - randomized self-checking bench for demux_deserializer (N=8 and N=5)
module tb_demux_deserializer;

  logic       clk = 1'b0;
  logic       reset, din, din_valid, sync;
  logic [2:0] sel8, sel5;
  logic [7:0] q8;
  logic [4:0] q5;
  logic       qv8, qv5, busy8, busy5, fe8, fe5;

  int tests = 0;
  int errors = 0;
  int cycle = 0;

  // Reference state: bit count and accumulated value of the partial word.
  int cnt8 = 0, acc8 = 0, mq8 = 0, cnt5 = 0, acc5 = 0, mq5 = 0;
  bit mqv8 = 0, mfe8 = 0, mqv5 = 0, mfe5 = 0;
  int qv8_cnt = 0, fe8_cnt = 0, last_qv = 0, prev_qv = 0;

  always #5 clk = ~clk;

  demux_deserializer #(.N(8)) u8 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync),
    .sel(sel8), .q(q8), .q_valid(qv8), .busy(busy8), .frame_err(fe8)
  );

  demux_deserializer #(.N(5)) u5 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync),
    .sel(sel5), .q(q5), .q_valid(qv5), .busy(busy5), .frame_err(fe5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, got, exp);
    end
  endtask

  task automatic model_step(input int n, input bit r, input bit s, input bit dv, input bit d,
                            inout int cnt, inout int acc, inout int mq,
                            inout bit mqv, inout bit mfe);
    mqv = 0;
    mfe = 0;
    if (r) begin
      cnt = 0; acc = 0; mq = 0;
    end else if (s) begin
      mfe = (cnt > 0);
      cnt = 0; acc = 0;
      if (dv) begin
        acc = int'(d);
        cnt = 1;
      end
    end else if (dv) begin
      acc = acc | (int'(d) << cnt);
      cnt++;
      if (cnt == n) begin
        mq = acc; mqv = 1; cnt = 0; acc = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit dv, input bit d);
    @(negedge clk);
    reset = r; sync = s; din_valid = dv; din = d;
    @(posedge clk);
    cycle++;
    model_step(8, r, s, dv, d, cnt8, acc8, mq8, mqv8, mfe8);
    model_step(5, r, s, dv, d, cnt5, acc5, mq5, mqv5, mfe5);
    #1;
    check("q8", q8, mq8);
    check("q_valid8", qv8, mqv8);
    check("sel8", sel8, cnt8);
    check("busy8", busy8, cnt8 > 0);
    check("frame_err8", fe8, mfe8);
    check("q5", q5, mq5);
    check("q_valid5", qv5, mqv5);
    check("sel5", sel5, cnt5);
    check("busy5", busy5, cnt5 > 0);
    check("frame_err5", fe5, mfe5);
    check("sel5_range", sel5 <= 3'd4, 1);
    if (qv8) begin
      qv8_cnt++;
      prev_qv = last_qv;
      last_qv = cycle;
    end
    if (fe8) fe8_cnt++;
  endtask

  task automatic send_bits(input logic [7:0] v, input int nb);
    logic [7:0] t;
    t = v;
    for (int i = 0; i < nb; i++) step(0, 0, 1, t[i]);
  endtask

  initial begin
    reset = 1; sync = 0; din_valid = 0; din = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_q8", q8, 0);
    check("rst_sel8", sel8, 0);
    check("rst_busy8", busy8, 0);

    // 1,0,1,1,0 -> N=5 word 5'b01101; N=8 left with a 5-bit partial word
    send_bits(8'b0000_1101, 5);
    check("n5_word", q5, 5'b01101);
    check("n5_sel_wrap", sel5, 0);

    // reset mid-frame on N=8 discards the partial word silently
    qv8_cnt = 0; fe8_cnt = 0;
    step(1, 0, 0, 0);
    check("rst_mid_q8", q8, 0);
    check("rst_mid_busy8", busy8, 0);
    check("rst_mid_sel8", sel8, 0);
    check("rst_mid_qv", qv8_cnt, 0);
    check("rst_mid_fe", fe8_cnt, 0);
    send_bits(8'h3C, 8);
    check("after_rst_word", q8, 8'h3C);

    step(1, 0, 0, 0);
    qv8_cnt = 0;
    send_bits(8'h64, 8);
    check("basic_word", q8, 8'h64);
    check("basic_pulses", qv8_cnt, 1);
    step(0, 0, 0, 0);
    check("basic_pulse_len", qv8, 0);

    // gap of three idle cycles after bit 4
    qv8_cnt = 0;
    send_bits(8'h64, 4);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      check("gap_sel", sel8, 4);
    end
    send_bits(8'h64 >> 4, 4);
    check("gap_word", q8, 8'h64);
    check("gap_pulses", qv8_cnt, 1);

    // back-to-back frames
    qv8_cnt = 0;
    send_bits(8'h64, 8);
    check("b2b_first", q8, 8'h64);
    send_bits(8'hA5, 8);
    check("b2b_second", q8, 8'hA5);
    check("b2b_pulses", qv8_cnt, 2);
    check("b2b_spacing", last_qv - prev_qv, 8);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    check("b2b_hold", q8, 8'hA5);

    // sync aborts a 3-bit partial word and carries bit 0 of the new frame
    step(1, 0, 0, 0);
    qv8_cnt = 0; fe8_cnt = 0;
    send_bits(8'h05, 3);
    step(0, 1, 1, 1);
    send_bits(8'b0100_0010, 7);
    check("sync_word", q8, 8'h85);
    check("sync_fe", fe8_cnt, 1);
    check("sync_pulses", qv8_cnt, 1);
    step(0, 1, 0, 0);
    check("sync_idle_fe", fe8, 0);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/demux_deserializer.md
Name: demux_deserializer

Overview:
- 1-to-N demultiplexing deserializer. Each accepted serial bit is steered into word position `sel` by an internal bit counter; a completed N-bit word is presented with a one-cycle valid pulse.
- Receiving end of the mux-based serial link: the transmitter steps its select 0..N-1 over a parallel word, LSB first.
- Sits between the serial line and downstream parallel logic.

Parameters:
- N, 8, word width in bits; legal range N >= 2.
- SW, $clog2(N), width of the select/bit counter. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled on this clock edge when high.
- sync  input  1  frame-start marker; forces the bit counter back to position 0.
- sel  output  SW  index the next accepted bit will be written to.
- q  output  N  last completed word; holds until the next word completes.
- q_valid  output  1  one-cycle pulse; q has just been updated.
- busy  output  1  high while a partial word (1..N-1 bits) is held.
- frame_err  output  1  one-cycle pulse; sync aborted a partial word.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset: on a clk edge with reset=1, the following values apply, taking priority over all other inputs:
  - q=0, q_valid=0, busy=0, frame_err=0, sel=0.
  - Shift/assembly register cleared; state=IDLE.
- States:
  - IDLE: sel=0, busy=0. din_valid=1 writes din to position 0, sets sel=1, and moves to COLLECT.
  - COLLECT: busy=1. din_valid=1 writes din to position sel and increments sel.
  - Word complete: when the bit at sel=N-1 is accepted, on that same edge:
    - q <= assembled word including that bit.
    - q_valid <= 1 for exactly one cycle.
    - sel <= 0; state <= IDLE.
  - din_valid=0 in either state: hold sel, hold state, hold the partial word. Gaps between bits are unlimited.
- Bit order: first accepted bit of a frame goes to q[0] and the last to q[N-1], i.e. LSB first.
- Latency: q and q_valid change on the edge that samples bit N-1, and are visible the cycle after that bit is presented.
- Back-to-back frames: a valid bit on the cycle q_valid is high is accepted as bit 0 of the next frame. There are no dead cycles; the sustained rate is one word per N cycles.
- q holds its value between completions. q_valid=0 otherwise.
- sync behaviour:
  - In COLLECT, sync=1 discards the partial word and pulses frame_err for one cycle.
  - In IDLE, sync=1 gives no frame_err.
  - sync=1 with din_valid=1: din is written to position 0, sel <= 1, state <= COLLECT. For N=2 this still needs a second bit to complete.
  - sync=1 with din_valid=0: sel <= 0, state <= IDLE.
  - sync never changes q and never generates q_valid.
- Unwritten bit positions are never exposed; q updates only on completion.
- Reset mid-frame: the partial word is discarded, with no q_valid and no frame_err.
- sel never exceeds N-1, including for non-power-of-2 N (wraps N-1 -> 0).

Test Plan:
- After reset, send 8 valid bits 0,0,1,0,0,1,1,0 on consecutive cycles -> q=8'h64, q_valid high for exactly one cycle after the 8th bit; busy=1 during bits 2-8; sel reads 0..7 at successive bit edges, then 0.
- Same bits with din_valid low for 3 cycles between bits 4 and 5 -> q=8'h64 once; sel holds at 4 during the gap; no spurious q_valid.
- Back-to-back frames 8'h64 then 8'hA5 with no idle cycle -> two q_valid pulses exactly 8 cycles apart; q=8'h64 then 8'hA5; q holds 8'hA5 afterwards.
- 3 bits of a frame, then sync=1 with din_valid=1, din=1, then 7 more bits 0,1,0,0,0,0,1 -> frame_err pulses once; q=8'h85; no q_valid before the 8th post-sync bit.
- Assert reset for one cycle after 5 bits, then send 8'h3C (8 bits) -> no q_valid and no frame_err from the aborted frame; all outputs 0 in the cycle after reset; next q=8'h3C.
- N=5 instance: send bits 1,0,1,1,0 -> q=5'b01101; sel wraps 4 -> 0; sel never reads 5-7.
